// File: rtl/nes_pkg.sv
// Shared encodings for the NES poll scheduler: FSM states, button bit positions and event field layout.
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_GAP,
    ST_PHI,
    ST_PLO,
    ST_COMMIT,
    ST_EMIT
  } nes_state_t;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  localparam int EVT_W      = 5;
  localparam int EVT_PORT   = 4;
  localparam int EVT_IDX_HI = 3;
  localparam int EVT_IDX_LO = 1;
  localparam int EVT_PRESS  = 0;

  function automatic logic [EVT_W-1:0] evt_pack(input logic port, input logic [2:0] idx,
                                                input logic press);
    logic [EVT_W-1:0] e;
    e = '0;
    e[EVT_PORT] = port;
    e[EVT_IDX_HI:EVT_IDX_LO] = idx;
    e[EVT_PRESS] = press;
    return e;
  endfunction

endpackage

// File: rtl/nes_poll_scheduler_if.sv
// Button event stream (valid/ready) between the poll scheduler and its consumer.
interface nes_poll_scheduler_if;
  import nes_pkg::*;

  logic             evt_valid;
  logic [EVT_W-1:0] evt_data;
  logic             evt_ready;

  modport master (output evt_valid, evt_data, input evt_ready);
  modport slave  (input evt_valid, evt_data, output evt_ready);
endinterface

// File: rtl/nes_evt_fifo.sv
// Synchronous event FIFO; output holds the last popped word while empty, and drop flags a lost push.
module nes_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] hold;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop frees the slot in the same cycle, so a push into a full FIFO still lands
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = empty ? hold : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        hold   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/nes_poll_scheduler.sv
// Two-port NES controller poller: latch/pulse sequencing, button publish and press/release events.
// Optional NES_DEBOUNCE_EN: a button bit only changes after two consecutive frames agree.
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | pins low, waiting for pending on a shift tick
// ST_LATCH  | latch high for 2 ticks, A sampled on exit
// ST_GAP    | latch low for 1 tick
// ST_PHI    | pulse high for 1 tick (cnt = k, 1..7)
// ST_PLO    | pulse low for 1 tick, bit 7-k sampled on exit
// ST_COMMIT | 1 clk: publish buttons, compute changed bits
// ST_EMIT   | 16 clks: one changed-bit scan index per clk (cnt = idx)
module nes_poll_scheduler
  import nes_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ = 100000000,
  parameter int SHIFTER_CLK      = 200000,
  parameter int UPDATE_100_HZ    = 100,
  parameter int CNTR_WIDTH       = 32,
  parameter int EVT_DEPTH        = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        poll_en,
  input  logic                        poll_req,
  input  logic [1:0]                  nes_data,
  output logic                        nes_latch,
  output logic                        nes_pulse,
  output logic                        busy,
  output logic                        poll_done,
  output logic [7:0]                  btns0,
  output logic [7:0]                  btns1,
  nes_poll_scheduler_if.master        evt,
  output logic                        evt_overflow,
  input  logic                        ovf_clr
);
  localparam int SH_DIV   = CLK_FREQUENCY_HZ / SHIFTER_CLK;
  localparam int POLL_DIV = CLK_FREQUENCY_HZ / UPDATE_100_HZ;

  nes_state_t            state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [CNTR_WIDTH-1:0] sh_cnt, poll_cnt;
  logic                  tick_sh, tick_poll, pending, enter_latch;
  logic [1:0]            data_s1, data_s2;
  logic [7:0]            raw0, raw1, new0, new1, nxt0, nxt1, chg0, chg1;
  logic                  samp_en;
  logic [2:0]            samp_pos, emit_btn;
  logic                  emit_port, push, fifo_full, fifo_empty, fifo_drop;
  logic [EVT_W-1:0]      push_data;

  assign tick_sh   = (sh_cnt == '0);
  assign tick_poll = poll_en && (poll_cnt == '0);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    samp_en     = 1'b0;
    samp_pos    = 3'd7;
    enter_latch = 1'b0;
    case (state)
      ST_IDLE:   if (tick_sh && pending) begin
                   state_n     = ST_LATCH;
                   cnt_n       = 4'd0;
                   enter_latch = 1'b1;
                 end
      ST_LATCH:  if (tick_sh) begin
                   if (cnt == 4'd1) begin
                     samp_en = 1'b1;
                     state_n = ST_GAP;
                   end else begin
                     cnt_n = cnt + 4'd1;
                   end
                 end
      ST_GAP:    if (tick_sh) begin
                   state_n = ST_PHI;
                   cnt_n   = 4'd1;
                 end
      ST_PHI:    if (tick_sh) state_n = ST_PLO;
      ST_PLO:    if (tick_sh) begin
                   samp_en  = 1'b1;
                   samp_pos = 3'd7 - cnt[2:0];
                   if (cnt == 4'd7) begin
                     state_n = ST_COMMIT;
                   end else begin
                     state_n = ST_PHI;
                     cnt_n   = cnt + 4'd1;
                   end
                 end
      ST_COMMIT: begin
                   state_n = ST_EMIT;
                   cnt_n   = 4'd0;
                 end
      ST_EMIT:   if (cnt == 4'd15) state_n = ST_IDLE;
                 else cnt_n = cnt + 4'd1;
      default:   state_n = ST_IDLE;
    endcase
  end

  assign new0 = ~raw0;
  assign new1 = ~raw1;

`ifdef NES_DEBOUNCE_EN
  logic [7:0] prev0, prev1;
  assign nxt0 = (~(new0 ^ prev0) & new0) | ((new0 ^ prev0) & btns0);
  assign nxt1 = (~(new1 ^ prev1) & new1) | ((new1 ^ prev1) & btns1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev0 <= '0;
      prev1 <= '0;
    end else if (state == ST_COMMIT) begin
      prev0 <= new0;
      prev1 <= new1;
    end
  end
`else
  assign nxt0 = new0;
  assign nxt1 = new1;
`endif

  // scan index 0..15 maps to port0 b7..b0 then port1 b7..b0
  assign emit_port = cnt[3];
  assign emit_btn  = ~cnt[2:0];
  assign push      = (state == ST_EMIT) && (emit_port ? chg1[emit_btn] : chg0[emit_btn]);
  assign push_data = evt_pack(emit_port, emit_btn, emit_port ? btns1[emit_btn] : btns0[emit_btn]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      sh_cnt       <= '0;
      poll_cnt     <= '0;
      pending      <= 1'b0;
      data_s1      <= 2'b11;
      data_s2      <= 2'b11;
      raw0         <= 8'hFF;
      raw1         <= 8'hFF;
      btns0        <= '0;
      btns1        <= '0;
      chg0         <= '0;
      chg1         <= '0;
      nes_latch    <= 1'b0;
      nes_pulse    <= 1'b0;
      poll_done    <= 1'b0;
      evt_overflow <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh_cnt    <= tick_sh ? CNTR_WIDTH'(SH_DIV - 1) : sh_cnt - CNTR_WIDTH'(1);
      if (poll_en) poll_cnt <= tick_poll ? CNTR_WIDTH'(POLL_DIV - 1) : poll_cnt - CNTR_WIDTH'(1);
      // a trigger landing on the LATCH entry cycle is kept for the next frame
      pending   <= tick_poll || poll_req || (pending && !enter_latch);
      data_s1   <= nes_data;
      data_s2   <= data_s1;
      nes_latch <= (state_n == ST_LATCH);
      nes_pulse <= (state_n == ST_PHI);
      poll_done <= (state == ST_EMIT) && (cnt == 4'd15);
      if (samp_en) begin
        raw0[samp_pos] <= data_s2[0];
        raw1[samp_pos] <= data_s2[1];
      end
      if (state == ST_COMMIT) begin
        btns0 <= nxt0;
        btns1 <= nxt1;
        chg0  <= nxt0 ^ btns0;
        chg1  <= nxt1 ^ btns1;
      end
      if (fifo_drop)    evt_overflow <= 1'b1;
      else if (ovf_clr) evt_overflow <= 1'b0;
    end
  end

  nes_evt_fifo #(.DEPTH(EVT_DEPTH), .W(EVT_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (push_data),
    .pop     (evt.evt_ready),
    .dout    (evt.evt_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  assign evt.evt_valid = !fifo_empty;

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// Directed bench for nes_poll_scheduler with a behavioural two-port NES controller model.
module tb_nes_poll_scheduler;
  import nes_pkg::*;

  localparam logic [7:0] ALL_BTNS = 8'((1 << BTN_A) | (1 << BTN_B) | (1 << BTN_SELECT) |
                                       (1 << BTN_START) | (1 << BTN_UP) | (1 << BTN_DOWN) |
                                       (1 << BTN_LEFT) | (1 << BTN_RIGHT));

  logic       clk = 1'b0;
  logic       reset_n, poll_en, poll_req, ovf_clr;
  logic [1:0] nes_data;
  logic       nes_latch, nes_pulse, busy, poll_done, evt_overflow;
  logic [7:0] btns0, btns1;

  nes_poll_scheduler_if evt();

  nes_poll_scheduler #(
    .CLK_FREQUENCY_HZ (2000),
    .SHIFTER_CLK      (500),
    .UPDATE_100_HZ    (10),
    .CNTR_WIDTH       (32),
    .EVT_DEPTH        (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .poll_en      (poll_en),
    .poll_req     (poll_req),
    .nes_data     (nes_data),
    .nes_latch    (nes_latch),
    .nes_pulse    (nes_pulse),
    .busy         (busy),
    .poll_done    (poll_done),
    .btns0        (btns0),
    .btns1        (btns1),
    .evt          (evt),
    .evt_overflow (evt_overflow),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  // controller model: parallel load while latched, shift on each pulse rise, data active-low
  logic [7:0] pressed0 = '0, pressed1 = '0, sh0 = '0, sh1 = '0;
  logic       pulse_q = 1'b0;
  int         cyc = 0, n_done = 0, n_rise = 0, n_latch_hi = 0, done_prev = 0, done_last = 0;

  assign nes_data = ~{sh1[7], sh0[7]};

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    pulse_q <= nes_pulse;
    if (nes_latch) begin
      sh0 <= pressed0;
      sh1 <= pressed1;
      n_latch_hi <= n_latch_hi + 1;
    end else if (nes_pulse && !pulse_q) begin
      sh0 <= {sh0[6:0], 1'b0};
      sh1 <= {sh1[6:0], 1'b0};
    end
    if (nes_pulse && !pulse_q) n_rise <= n_rise + 1;
    if (poll_done) begin
      n_done    <= n_done + 1;
      done_prev <= done_last;
      done_last <= cyc;
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (poll_done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, " poll_done"}, 32'(seen), 1);
  endtask

  task automatic poll_once(input string tag);
    @(negedge clk);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    wait_done(tag);
  endtask

  // with debounce a new level needs two agreeing frames before it is published
  task automatic settle(input string tag);
`ifdef NES_DEBOUNCE_EN
    poll_once({tag, " pre"});
`endif
    poll_once(tag);
  endtask

  task automatic pop_chk(input string tag, input logic [4:0] exp);
    check({tag, " valid"}, 32'(evt.evt_valid), 1);
    check({tag, " data"}, 32'(evt.evt_data), 32'(exp));
    evt.evt_ready = 1'b1;
    @(negedge clk);
    evt.evt_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit idle = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        idle = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, " idle"}, 32'(idle), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, l0;
    bit hit;
    reset_n = 1'b0;
    poll_en = 1'b0;
    poll_req = 1'b0;
    ovf_clr = 1'b0;
    evt.evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst latch", 32'(nes_latch), 0);
    check("rst pulse", 32'(nes_pulse), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(poll_done), 0);
    check("rst btns0", 32'(btns0), 0);
    check("rst btns1", 32'(btns1), 0);
    check("rst valid", 32'(evt.evt_valid), 0);
    check("rst data", 32'(evt.evt_data), 0);
    check("rst ovf", 32'(evt_overflow), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // periodic polling, nothing pressed: poll period is 200 clks here
    d0 = n_done; r0 = n_rise; l0 = n_latch_hi;
    poll_en = 1'b1;
    repeat (590) @(negedge clk);
    poll_en = 1'b0;
    wait_idle("t1");
    check("t1 frames", 32'(n_done - d0), 3);
    check("t1 pulses", 32'(n_rise - r0), 21);
    check("t1 latch clks", 32'(n_latch_hi - l0), 24);
    check("t1 period", 32'(done_last - done_prev), 200);
    check("t1 btns0", 32'(btns0), 0);
    check("t1 btns1", 32'(btns1), 0);
    check("t1 valid", 32'(evt.evt_valid), 0);

    // A pressed on port0
    pressed0 = 8'(1 << BTN_A);
    settle("t2");
    @(negedge clk);
    check("t2 done width", 32'(poll_done), 0);
    check("t2 btns0", 32'(btns0), 32'h80);
    check("t2 btns1", 32'(btns1), 0);
    pop_chk("t2 evt", 5'b0_111_1);
    check("t2 empty", 32'(evt.evt_valid), 0);
    check("t2 hold", 32'(evt.evt_data), 32'h0F);

    // A released
    pressed0 = 8'h00;
    settle("t3");
    check("t3 btns0", 32'(btns0), 0);
    pop_chk("t3 evt", 5'b0_111_0);
    check("t3 empty", 32'(evt.evt_valid), 0);

    // everything pressed on both ports with no consumer: 8 queued, 8 dropped
    pressed0 = ALL_BTNS;
    pressed1 = ALL_BTNS;
    settle("t4");
    check("t4 btns0", 32'(btns0), 32'hFF);
    check("t4 btns1", 32'(btns1), 32'hFF);
    check("t4 ovf", 32'(evt_overflow), 1);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("t4 evt%0d", i), {1'b0, 3'(7 - i), 1'b1});
    check("t4 drained", 32'(evt.evt_valid), 0);
    check("t4 ovf sticky", 32'(evt_overflow), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t4 ovf clr", 32'(evt_overflow), 0);
    pressed0 = 8'h00;
    pressed1 = 8'h00;
    evt.evt_ready = 1'b1;
    settle("t4 rel");
    @(negedge clk);
    evt.evt_ready = 1'b0;
    check("t4 rel valid", 32'(evt.evt_valid), 0);
    check("t4 rel ovf", 32'(evt_overflow), 0);
    check("t4 rel btns1", 32'(btns1), 0);

    // three requests while busy collapse into one extra frame
    d0 = n_done;
    @(negedge clk);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check("t5 busy", 32'(hit), 1);
    repeat (3) begin
      repeat (6) @(negedge clk);
      poll_req = 1'b1;
      @(negedge clk);
      poll_req = 1'b0;
    end
    repeat (500) @(negedge clk);
    check("t5 frames", 32'(n_done - d0), 2);

    // reset in the middle of PHI(3)
    pressed0 = 8'(1 << BTN_UP);
    evt.evt_ready = 1'b1;
    settle("t6 pre");
    @(negedge clk);
    evt.evt_ready = 1'b0;
    check("t6 pre btns0", 32'(btns0), 32'h08);
    r0 = n_rise;
    @(negedge clk);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_rise == r0 + 3) begin hit = 1'b1; break; end
    end
    check("t6 reach phi3", 32'(hit), 1);
    check("t6 in phi", 32'(nes_pulse), 1);
    #1 reset_n = 1'b0;
    #1;
    check("t6 latch", 32'(nes_latch), 0);
    check("t6 pulse", 32'(nes_pulse), 0);
    check("t6 btns0", 32'(btns0), 0);
    check("t6 busy", 32'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    settle("t6 post");
    check("t6 post btns0", 32'(btns0), 32'h08);
    pop_chk("t6 post evt", 5'b0_011_1);
    check("t6 post empty", 32'(evt.evt_valid), 0);

    // one-frame glitch on Up
    pressed0 = 8'h00;
    poll_once("t7 glitch");
`ifdef NES_DEBOUNCE_EN
    check("t7 btns0 held", 32'(btns0), 32'h08);
    check("t7 no evt", 32'(evt.evt_valid), 0);
`else
    check("t7 btns0 rel", 32'(btns0), 0);
    pop_chk("t7 rel evt", 5'b0_011_0);
`endif
    pressed0 = 8'(1 << BTN_UP);
    poll_once("t7 back");
    check("t7 btns0", 32'(btns0), 32'h08);
`ifdef NES_DEBOUNCE_EN
    check("t7 still no evt", 32'(evt.evt_valid), 0);
`else
    pop_chk("t7 press evt", 5'b0_011_1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
